uart_tx_core: RTL and testbench
===============================

// Module: uart_tx_core
// PURPOSE
//  Self-contained UART transmitter: integer clock divider (oversampling tick + baud tick) plus 8N1-style serializer.
//  Accepts a parallel word on a ready level, emits start bit, DATA_BITS LSB-first, one stop bit on tx_serial_out.
//  Sits between a host register/FIFO and the TX pin; baudclk_out/divclk_out exported for scoreboards/debug.
// PARAMETERS
//  CLOCK_IN           100_000_000  sysclk frequency, Hz
//  BAUD_RATE          115_200      line rate, bit/s
//  OVERSAMPLING_RATE  8            div ticks per bit (even, >=2)
//  DATA_BITS          8            payload bits per frame (1..16)
// PORTS
//  sysclk_in      in   1          sole clock, all logic on rising edge
//  nrst_in        in   1          reset, synchronous, active-low
//  data_rdy_in    in   1          level request: word on tx_data_in valid
//  tx_data_in     in   DATA_BITS  word to send, captured at frame start
//  tx_serial_out  out  1          serial line, idle high
//  tx_busy_out    out  1          high from frame start until stop bit ends
//  tx_done_out    out  1          1-cycle pulse at end of stop bit
//  baudclk_out    out  1          bit-rate square wave, rises at each bit boundary
//  divclk_out     out  1          oversample-rate square wave
// BEHAVIOUR
//  Divider: DIV = CLOCK_IN/(BAUD_RATE*OVERSAMPLING_RATE), truncated (defaults: 108). div_cnt 0..DIV-1; div_tick when div_cnt==DIV-1.
//  divclk_out high while div_cnt < DIV/2. os_cnt 0..OVERSAMPLING_RATE-1 advances on div_tick.
//  baud_tick = div_tick && os_cnt==OVERSAMPLING_RATE-1; bit time = DIV*OVERSAMPLING_RATE cycles (864 = 8640 ns at defaults).
//  baudclk_out high while os_cnt < OVERSAMPLING_RATE/2: rises at the bit boundary, falls mid-bit (safe sample point).
//  Divider free-runs from reset; never resynchronised to data_rdy_in.
//  FSM states IDLE, START, DATA, STOP; all state changes and tx_serial_out updates registered on baud_tick only.
//   IDLE : line=1, busy=0. On baud_tick with data_rdy_in=1: latch tx_data_in into shift reg, bit_idx=0 -> START.
//   START: line=0, busy=1. Next baud_tick -> DATA.
//   DATA : line=shift[bit_idx] (LSB first). On baud_tick: bit_idx==DATA_BITS-1 -> STOP, else bit_idx++.
//   STOP : line=1. On baud_tick -> IDLE, busy=0, tx_done_out=1 for that one cycle.
//  Request latency: start edge at first baud_tick with data_rdy_in=1 seen in IDLE (0..1 bit time).
//  tx_data_in may change any time after START entered; frame uses latched copy.
//  data_rdy_in high through the frame does not restart it; after STOP, IDLE >=1 bit time before next START.
//  data_rdy_in ignored outside IDLE; no queuing.
//  Reset (nrst_in=0 at rising edge): div_cnt=0, os_cnt=0, state=IDLE, shift=0, bit_idx=0,
//   tx_serial_out=1, tx_busy_out=0, tx_done_out=0, baudclk_out=1, divclk_out=1 (counters zeroed).
//  Reset mid-frame: frame aborted, line high next cycle, no done pulse.
//  Line is fully registered, no glitches between baud ticks.
// TESTING
//  1 Reset: nrst_in low 1 cycle -> tx_serial_out=1, busy=0, done=0; line idles high indefinitely with data_rdy_in=0.
//  2 Single frame 0xA5: rdy=1 until start falls -> line 0,1,0,1,0,0,1,0,1,1 each 864 cycles; negedge-baudclk samples = 0xA5.
//  3 Data change: tx_data_in 0x3C -> 0xFF right after start edge -> frame still carries 0x3C.
//  4 Handshake: busy rises with start edge, falls with done; done exactly 1 cycle, coincident with stop-bit end.
//  5 Back-to-back 16 random words, rdy re-raised after each done -> all 16 received match, idle gap >=1 bit.
//  6 Reset at DATA bit 3 -> line high next cycle, busy=0, no done; next request sends full frame correctly.

Source files
------------

// File: rtl/uart_tx_core.sv
// UART transmitter: free-running integer divider (oversample + baud ticks) and a
// start/data/stop serializer whose state and line only move on baud ticks.
module uart_tx_core #(
    parameter int unsigned CLOCK_IN          = 100_000_000,
    parameter int unsigned BAUD_RATE         = 115_200,
    parameter int unsigned OVERSAMPLING_RATE = 8,
    parameter int unsigned DATA_BITS         = 8
) (
    input  logic                 sysclk_in,
    input  logic                 nrst_in,
    input  logic                 data_rdy_in,
    input  logic [DATA_BITS-1:0] tx_data_in,
    output logic                 tx_serial_out,
    output logic                 tx_busy_out,
    output logic                 tx_done_out,
    output logic                 baudclk_out,
    output logic                 divclk_out
);

    localparam int unsigned DIV   = CLOCK_IN / (BAUD_RATE * OVERSAMPLING_RATE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLING_RATE);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d, bit_idx_nx;
    logic                 line_d, busy_d, done_d;
    logic                 div_tick, baud_tick;

    // Divider: div_cnt wraps every DIV cycles, os_cnt every bit time
    always_comb begin
        div_tick  = (div_cnt_q == DIV_W'(DIV - 1));
        baud_tick = div_tick && (os_cnt_q == OS_W'(OVERSAMPLING_RATE - 1));
        div_cnt_d = div_tick ? '0 : div_cnt_q + DIV_W'(1);
        os_cnt_d  = os_cnt_q;
        if (div_tick) begin
            os_cnt_d = (os_cnt_q == OS_W'(OVERSAMPLING_RATE - 1)) ? '0 : os_cnt_q + OS_W'(1);
        end
    end

    // Serializer next-state; line value is computed for the state being entered
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        line_d     = tx_serial_out;
        busy_d     = tx_busy_out;
        done_d     = 1'b0;
        bit_idx_nx = bit_idx_q + IDX_W'(1);
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (data_rdy_in) begin
                        shift_d   = tx_data_in;
                        bit_idx_d = '0;
                        line_d    = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = START;
                    end
                end
                START: begin
                    line_d  = shift_q[0];
                    state_d = DATA;
                end
                DATA: begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_nx;
                        line_d    = shift_q[bit_idx_nx];
                    end
                end
                STOP: begin
                    line_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs; debug clocks follow the next counter values
    always_ff @(posedge sysclk_in) begin
        if (!nrst_in) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            os_cnt_q      <= '0;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            tx_serial_out <= 1'b1;
            tx_busy_out   <= 1'b0;
            tx_done_out   <= 1'b0;
            baudclk_out   <= 1'b1;
            divclk_out    <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            os_cnt_q      <= os_cnt_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            tx_serial_out <= line_d;
            tx_busy_out   <= busy_d;
            tx_done_out   <= done_d;
            baudclk_out   <= (os_cnt_d < OS_W'(OVERSAMPLING_RATE / 2));
            divclk_out    <= (div_cnt_d < DIV_W'(DIV / 2));
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: divider phase, frame timing/content, handshake, back-to-back
// random words and mid-frame reset, checked against an arithmetic bit-time model.
module tb_uart_tx_core;

    localparam int unsigned CLK_HZ = 100_000_000;
    localparam int unsigned BAUD   = 2_400_000;
    localparam int unsigned OSR    = 8;
    localparam int unsigned DBITS  = 8;
    localparam int DIV   = int'(CLK_HZ / (BAUD * OSR));
    localparam int BIT   = DIV * int'(OSR);
    localparam int FRAME = (int'(DBITS) + 2) * BIT;

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic       rdy  = 1'b0;
    logic [7:0] data = 8'h00;
    logic       line, busy, done, baud, divc;

    uart_tx_core #(
        .CLOCK_IN(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLING_RATE(OSR), .DATA_BITS(DBITS)
    ) dut (
        .sysclk_in(clk), .nrst_in(nrst), .data_rdy_in(rdy), .tx_data_in(data),
        .tx_serial_out(line), .tx_busy_out(busy), .tx_done_out(done),
        .baudclk_out(baud), .divclk_out(divc)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset edge
    int cyc = 0;
    always @(posedge clk) cyc <= !nrst ? 0 : cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int last_end = -1;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        nrst = 1'b0;
        rdy  = 1'b0;
        @(negedge clk);
        check("rst_line", 64'(line), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_baudclk", 64'(baud), 64'(1));
        check("rst_divclk", 64'(divc), 64'(1));
        nrst = 1'b1;
        last_end = -1;
    endtask

    // Raise the request, expect the start edge at the next bit boundary after rdy is seen
    task automatic start_frame(input logic [7:0] w, input int delay, output bit ok);
        int k0;
        int s_exp;
        repeat (delay) @(negedge clk);
        data  = w;
        rdy   = 1'b1;
        k0    = cyc;
        s_exp = ((k0 + BIT) / BIT) * BIT;
        ok    = 1'b0;
        for (int i = 0; i < 3 * BIT && !ok; i++) begin
            @(negedge clk);
            if (line === 1'b0) ok = 1'b1;
        end
        check("start_found", 64'(ok), 64'(1));
        if (ok) begin
            check("start_cycle", 64'(cyc), 64'(s_exp));
            check("busy_at_start", 64'(busy), 64'(1));
            if (last_end >= 0) check("idle_gap_ge_bit", 64'((cyc - last_end) >= BIT), 64'(1));
        end
        rdy = 1'b0;
    endtask

    // Walk the frame cycle by cycle from the start-edge sample; decode at baudclk falls
    task automatic scan_frame(input logic [7:0] w, input logic [7:0] chg, input bit do_chg,
                              output logic [7:0] rx_word);
        int line_err = 0;
        int busy_err = 0;
        int done_err = 0;
        int rx_n = 0;
        logic [9:0] rx = '0;
        logic [9:0] bits;
        logic pb;
        bits = {1'b1, w, 1'b0};
        pb   = baud;
        for (int t = 0; t < FRAME; t++) begin
            if (line !== bits[t / BIT]) line_err++;
            if (busy !== 1'b1) busy_err++;
            if (done !== 1'b0) done_err++;
            if (pb === 1'b1 && baud === 1'b0) begin
                if (rx_n < 10) rx[rx_n] = line;
                rx_n++;
            end
            pb = baud;
            if (t == 0 && do_chg) data = chg;
            @(negedge clk);
        end
        check("frame_line_cycles", 64'(line_err), 64'(0));
        check("frame_busy_cycles", 64'(busy_err), 64'(0));
        check("frame_no_early_done", 64'(done_err), 64'(0));
        check("rx_bit_count", 64'(rx_n), 64'(10));
        check("rx_start_stop", 64'({rx[9], rx[0]}), 64'(2'b10));
        check("end_done", 64'(done), 64'(1));
        check("end_busy", 64'(busy), 64'(0));
        check("end_line", 64'(line), 64'(1));
        last_end = cyc;
        rx_word  = rx[8:1];
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
    endtask

    initial begin
        bit ok;
        logic [7:0] w;
        logic [7:0] rxw;
        int div_err, baud_err, idle_err;

        // Reset and idle line, divider phase from the reset edge
        apply_reset();
        div_err = 0; baud_err = 0; idle_err = 0;
        for (int k = 1; k <= 3 * BIT; k++) begin
            @(negedge clk);
            if (divc !== ((k % DIV) < DIV / 2)) div_err++;
            if (baud !== (((k / DIV) % int'(OSR)) < int'(OSR) / 2)) baud_err++;
            if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_err++;
        end
        check("divclk_phase", 64'(div_err), 64'(0));
        check("baudclk_phase", 64'(baud_err), 64'(0));
        check("idle_high", 64'(idle_err), 64'(0));

        // Single frame 0xA5
        start_frame(8'hA5, 3, ok);
        if (ok) begin
            scan_frame(8'hA5, 8'h00, 1'b0, rxw);
            check("rx_a5", 64'(rxw), 64'(8'hA5));
        end

        // Data changed right after start edge: latched copy is sent
        start_frame(8'h3C, int'($urandom_range(0, BIT)), ok);
        if (ok) begin
            scan_frame(8'h3C, 8'hFF, 1'b1, rxw);
            check("rx_latched_3c", 64'(rxw), 64'(8'h3C));
        end

        // Back-to-back random words through a scoreboard queue
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            exp_q.push_back(w);
            start_frame(w, (i % 4 == 3) ? int'($urandom_range(1, 2 * BIT)) : 0, ok);
            if (ok) begin
                scan_frame(w, 8'($urandom), 1'b1, rxw);
                check("rx_random", 64'(rxw), 64'(exp_q.pop_front()));
            end else begin
                void'(exp_q.pop_front());
            end
        end

        // Reset in the middle of data bit 3
        w = 8'($urandom) | 8'h08;
        start_frame(w, 0, ok);
        if (ok) begin
            repeat (4 * BIT + BIT / 2) @(negedge clk);
            check("pre_abort_bit3", 64'(line), 64'(w[3]));
            nrst = 1'b0;
            @(negedge clk);
            check("abort_line", 64'(line), 64'(1));
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_done", 64'(done), 64'(0));
            nrst = 1'b1;
            last_end = -1;
            idle_err = 0;
            for (int k = 0; k < 2 * BIT; k++) begin
                @(negedge clk);
                if (done !== 1'b0 || line !== 1'b1 || busy !== 1'b0) idle_err++;
            end
            check("abort_quiet", 64'(idle_err), 64'(0));
        end

        // Full frame after the abort
        w = 8'($urandom);
        start_frame(w, 1, ok);
        if (ok) begin
            scan_frame(w, 8'h00, 1'b0, rxw);
            check("rx_after_abort", 64'(rxw), 64'(w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
